// File: rtl/sync_debounce_multi.sv
// ---------------------------------------------------------------------------
// sync_debounce_multi
//   Multi-channel input conditioner: every channel synchronizes a raw
//   asynchronous input, debounces it with a tick-driven agreement counter,
//   reports level changes as one-cycle pulses, and flags a long-press
//   ("hold") once the debounced level has stayed high for HOLD_COUNT ticks.
//
// Parameters
//   CHANNELS     number of independent channels (1..32)
//   SYNC_STAGES  synchronizer depth per channel (>= 2)
//   MAX_COUNT    consecutive disagreeing ticks needed to accept a new level
//   HOLD_COUNT   ticks out must stay high before hold asserts
//   RESET_LEVEL  debounced level loaded into every channel at reset
//
// Ports
//   clock       rising-edge clock for all state
//   reset_n     asynchronous active-low reset
//   tick        sample enable for the debounce and hold counters
//   in          raw asynchronous inputs, one bit per channel
//   out         debounced, synchronized level
//   edj         one-cycle pulse on any change of out
//   rise / fall one-cycle pulse on 0->1 / 1->0 change of out
//   hold        high while out has been high for at least HOLD_COUNT ticks
//   hold_pulse  one-cycle pulse in the first cycle hold is high
//   any_edj     OR of edj, same timing as edj
//   Every output comes straight from a flip-flop.
// ---------------------------------------------------------------------------
module sync_debounce_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_COUNT   = 4,
  parameter int HOLD_COUNT  = 16,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                tick,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] edj,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold,
  output logic [CHANNELS-1:0] hold_pulse,
  output logic                any_edj
);

  localparam int CNT_W  = $clog2(MAX_COUNT + 1);
  localparam int HOLD_W = $clog2(HOLD_COUNT + 1);
  // Counter value on which the next disagreeing tick commits the new level.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_COUNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(HOLD_COUNT);

  logic [CHANNELS-1:0] edj_nx_s;
  logic                any_edj_r;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nx_s;
    logic                   out_r;
    logic                   out_nx_s;
    logic [HOLD_W-1:0]      hcnt_r;
    logic [HOLD_W-1:0]      hcnt_nx_s;
    logic                   edj_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   hold_r;
    logic                   hold_pulse_r;

    assign s_s = sync_r[SYNC_STAGES-1];

    // Debounce decision: count ticks of disagreement, commit on the last one.
    always_comb begin
      cnt_nx_s = cnt_r;
      out_nx_s = out_r;
      if (s_s == out_r) begin
        // Any agreement restarts the count, even without a tick.
        cnt_nx_s = {CNT_W{1'b0}};
      end else if (tick) begin
        if (cnt_r == CNT_LAST) begin
          out_nx_s = s_s;
          cnt_nx_s = {CNT_W{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_nx_s = cnt_r;
      end
    end

    // Hold counter: cleared on the same edge out goes (or stays) low so hold
    // never outlives out; counts only ticks that occur while out is already high.
    always_comb begin
      hcnt_nx_s = hcnt_r;
      if (!out_nx_s) begin
        hcnt_nx_s = {HOLD_W{1'b0}};
      end else if (out_r && tick && (hcnt_r != HOLD_FULL)) begin
        hcnt_nx_s = hcnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
      end else begin
        hcnt_nx_s = hcnt_r;
      end
    end

    assign edj_nx_s[g] = out_nx_s ^ out_r;

    // Per-channel state and registered event outputs.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sync_r       <= {SYNC_STAGES{RESET_LEVEL}};
        cnt_r        <= {CNT_W{1'b0}};
        out_r        <= RESET_LEVEL;
        hcnt_r       <= {HOLD_W{1'b0}};
        edj_r        <= 1'b0;
        rise_r       <= 1'b0;
        fall_r       <= 1'b0;
        hold_r       <= 1'b0;
        hold_pulse_r <= 1'b0;
      end else begin
        sync_r       <= {sync_r[SYNC_STAGES-2:0], in[g]};
        cnt_r        <= cnt_nx_s;
        out_r        <= out_nx_s;
        hcnt_r       <= hcnt_nx_s;
        edj_r        <= out_nx_s ^ out_r;
        rise_r       <= out_nx_s & ~out_r;
        fall_r       <= ~out_nx_s & out_r;
        hold_r       <= (hcnt_nx_s == HOLD_FULL);
        hold_pulse_r <= (hcnt_nx_s == HOLD_FULL) && (hcnt_r != HOLD_FULL);
      end
    end

    assign out[g]        = out_r;
    assign edj[g]        = edj_r;
    assign rise[g]       = rise_r;
    assign fall[g]       = fall_r;
    assign hold[g]       = hold_r;
    assign hold_pulse[g] = hold_pulse_r;
  end : g_ch

  // Summary edge flag, registered alongside the per-channel edj bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      any_edj_r <= 1'b0;
    end else begin
      any_edj_r <= |edj_nx_s;
    end
  end

  assign any_edj = any_edj_r;

endmodule

// File: tb/tb_sync_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_sync_debounce_multi
//   Self-checking bench for sync_debounce_multi (HOLD_COUNT = 8, other
//   parameters at default). A behavioural model runs alongside the DUT and
//   is compared every cycle; directed table and sequences pin down the
//   exact edge timing of transitions, glitches, hold, tick gating and reset.
// ---------------------------------------------------------------------------
module tb_sync_debounce_multi;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int MC = 4;
  localparam int HC = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          tick;
  logic [CH-1:0] in;
  logic [CH-1:0] out, edj, rise, fall, hold, hold_pulse;
  logic          any_edj;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sync_debounce_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .MAX_COUNT(MC), .HOLD_COUNT(HC), .RESET_LEVEL(1'b0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick), .in(in),
    .out(out), .edj(edj), .rise(rise), .fall(fall),
    .hold(hold), .hold_pulse(hold_pulse), .any_edj(any_edj)
  );

  // ---------------- behavioural reference model ----------------
  logic [CH-1:0] m_sync [SS];
  int            m_dis  [CH];   // ticks of disagreement seen so far
  int            m_high [CH];   // ticks spent high, saturating at HC
  logic [CH-1:0] m_out, m_edj, m_rise, m_fall, m_hold, m_hp;
  logic          m_any;

  task automatic model_reset();
    for (int i = 0; i < SS; i++) m_sync[i] = '0;
    for (int c = 0; c < CH; c++) begin m_dis[c] = 0; m_high[c] = 0; end
    m_out = '0; m_edj = '0; m_rise = '0; m_fall = '0; m_hold = '0; m_hp = '0; m_any = 1'b0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] s, prev_out, prev_hold;
    if (!reset_n) begin
      model_reset();
      return;
    end
    s         = m_sync[SS-1];
    prev_out  = m_out;
    prev_hold = m_hold;
    for (int i = SS-1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = in;
    for (int c = 0; c < CH; c++) begin
      if (s[c] == prev_out[c]) m_dis[c] = 0;
      else if (tick) begin
        m_dis[c] = m_dis[c] + 1;
        if (m_dis[c] >= MC) begin
          m_out[c] = s[c];
          m_dis[c] = 0;
        end
      end
      if (!m_out[c]) m_high[c] = 0;
      else if (prev_out[c] && tick) m_high[c] = (m_high[c] + 1 > HC) ? HC : m_high[c] + 1;
      m_hold[c] = (m_high[c] >= HC);
    end
    m_edj  = m_out ^ prev_out;
    m_rise = m_out & ~prev_out;
    m_fall = ~m_out & prev_out;
    m_hp   = m_hold & ~prev_hold;
    m_any  = |m_edj;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock edge: advance model at the edge, compare at the falling edge.
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("model", {7'd0, out, edj, rise, fall, hold, hold_pulse, any_edj},
                   {7'd0, m_out, m_edj, m_rise, m_fall, m_hold, m_hp, m_any});
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in = '0; tick = 1'b1;
    step(); step();
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] all_outs();
    return {7'd0, out, edj, rise, fall, hold, hold_pulse, any_edj};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [CH-1:0] vin;
    logic [CH-1:0] eout;
    logic [CH-1:0] erise;
    logic          eany;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rise_edge;
    // in[0] 0->1 held: out[0] settles on the sixth edge, pulse only there.
    tbl[0] = '{4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[1] = '{4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[2] = '{4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[3] = '{4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[4] = '{4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[5] = '{4'b0001, 4'b0001, 4'b0001, 1'b1};
    tbl[6] = '{4'b0001, 4'b0001, 4'b0000, 1'b0};
    tbl[7] = '{4'b0001, 4'b0001, 4'b0000, 1'b0};

    model_reset();
    reset_n = 1'b0; in = '0; tick = 1'b1;
    @(negedge clock); #1;
    check("reset_state", all_outs(), 32'd0);
    reset_n = 1'b1;

    // Table: single-channel rise timing
    for (int i = 0; i < 8; i++) begin
      in = tbl[i].vin;
      step();
      check($sformatf("tbl_out[%0d]", i), {28'd0, out}, {28'd0, tbl[i].eout});
      check($sformatf("tbl_rise[%0d]", i), {28'd0, rise}, {28'd0, tbl[i].erise});
      check($sformatf("tbl_edj[%0d]", i), {28'd0, edj}, {28'd0, tbl[i].erise});
      check($sformatf("tbl_any[%0d]", i), {31'd0, any_edj}, {31'd0, tbl[i].eany});
    end

    // Glitch shorter than MAX_COUNT ticks is swallowed.
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      in = (k <= 3) ? 4'b0010 : 4'b0000;
      step();
      check("glitch_quiet", {out, edj, rise, fall, 16'd0}, 32'd0);
    end

    // Hold timing on channel 1.
    do_reset();
    for (int k = 1; k <= 28; k++) begin
      in = (k <= 20) ? 4'b0010 : 4'b0000;
      step();
      if (k == 13) check("hold_before", {30'd0, hold[1], hold_pulse[1]}, 32'd0);
      if (k == 14) check("hold_assert", {30'd0, hold[1], hold_pulse[1]}, 32'd3);
      if (k == 15) check("hold_level", {30'd0, hold[1], hold_pulse[1]}, 32'd2);
      if (k == 25) check("hold_before_fall", {30'd0, hold[1], out[1]}, 32'd3);
      if (k == 26) check("hold_drops_with_out", {29'd0, hold[1], out[1], fall[1]}, 32'd1);
    end

    // Simultaneous rise on ch2 and fall on ch3.
    do_reset();
    in = 4'b1000;
    for (int k = 0; k < 8; k++) step();
    check("ch3_settled", {28'd0, out}, 32'h8);
    in = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("simul_before", {28'd0, edj}, 32'd0);
    end
    check("simul_rise", {28'd0, rise}, 32'h4);
    check("simul_fall", {28'd0, fall}, 32'h8);
    check("simul_edj", {28'd0, edj}, 32'hC);
    check("simul_any", {31'd0, any_edj}, 32'd1);

    // Tick one cycle in four: out[0] commits on the 4th tick after sync (edge 16).
    do_reset();
    in = 4'b0001;
    rise_edge = 0;
    for (int k = 1; k <= 24; k++) begin
      tick = (k % 4 == 0);
      step();
      if (rise[0] && rise_edge == 0) rise_edge = k;
      if (k == 15) check("tick_gate_before", {31'd0, out[0]}, 32'd0);
    end
    check("tick_gate_rise_edge", rise_edge, 32'd16);
    tick = 1'b1;

    // Reset mid-count: immediate clear, then normal debounce after release.
    do_reset();
    in = 4'b0001;
    for (int k = 0; k < 4; k++) step();   // counter at 2
    reset_n = 1'b0;
    #1;
    check("reset_mid_immediate", all_outs(), 32'd0);
    step();
    check("reset_mid_no_pulse", all_outs(), 32'd0);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("post_reset_before", {31'd0, out[0]}, 32'd0);
    end
    check("post_reset_rise", {30'd0, out[0], rise[0]}, 32'd3);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) == 0) in[c] = ~in[c];
      tick    = ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
